// File: rtl/i2s_primary_tx.sv
// I2S primary transmitter: generates sck/ws from the system clock and shifts out
// one stereo sample per 64-bit frame from a single-entry holding buffer.
module i2s_primary_tx #(
  parameter int DIVIDER = 8,
  parameter int BITS    = 16
) (
  input  logic            ck,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] left,
  input  logic [BITS-1:0] right,
  output logic            sck,
  output logic            ws,
  output logic            sd,
  output logic            en,
  output logic [5:0]      frame_posn,
  output logic            underrun
);

  localparam int PW = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIVIDER - 1);
  localparam logic [PW-1:0] PS_RISE = PW'(DIVIDER / 2 - 1);
  localparam logic [5:0]    L_LAST  = 6'(BITS);
  localparam logic [5:0]    R_LAST  = 6'(32 + BITS);

  logic [PW-1:0]   prescale_r;
  logic            sck_r, ws_r, sd_r, en_r, underrun_r, full_r, in_ready_r;
  logic [5:0]      posn_r;
  logic [BITS-1:0] buf_l_r, buf_r_r, sh_l_r, sh_r_r;

  logic            fall_s, rise_s, frame_start_s, accept_s, load_s, full_nx_s, sd_nx_s;
  logic [5:0]      posn_nx_s;
  logic [BITS-1:0] sh_l_nx_s, sh_r_nx_s;

  // Next-state logic for buffer occupancy, shift registers and serial bit
  always_comb begin
    fall_s        = (prescale_r == PS_LAST);
    rise_s        = (prescale_r == PS_RISE);
    posn_nx_s     = posn_r + 6'd1;
    frame_start_s = fall_s && (posn_nx_s == 6'd0);
    accept_s      = in_valid && in_ready_r;
    load_s        = frame_start_s && full_r;
    full_nx_s     = full_r;
    sh_l_nx_s     = sh_l_r;
    sh_r_nx_s     = sh_r_r;
    sd_nx_s       = 1'b0;

    if (accept_s) begin
      full_nx_s = 1'b1;
    end else if (load_s) begin
      full_nx_s = 1'b0;
    end else begin
      full_nx_s = full_r;
    end

    // Sample data is consumed MSB first, one position after each ws edge
    if (frame_start_s) begin
      sh_l_nx_s = full_r ? buf_l_r : {BITS{1'b0}};
      sh_r_nx_s = full_r ? buf_r_r : {BITS{1'b0}};
    end else if (fall_s && (posn_nx_s >= 6'd1) && (posn_nx_s <= L_LAST)) begin
      sd_nx_s   = sh_l_r[BITS-1];
      sh_l_nx_s = sh_l_r << 1'b1;
    end else if (fall_s && (posn_nx_s >= 6'd33) && (posn_nx_s <= R_LAST)) begin
      sd_nx_s   = sh_r_r[BITS-1];
      sh_r_nx_s = sh_r_r << 1'b1;
    end else begin
      sd_nx_s = 1'b0;
    end
  end

  // State registers; frame_posn resets to 63 so the first fall starts a frame
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      prescale_r <= {PW{1'b0}};
      sck_r      <= 1'b1;
      ws_r       <= 1'b1;
      sd_r       <= 1'b0;
      en_r       <= 1'b0;
      underrun_r <= 1'b0;
      posn_r     <= 6'd63;
      full_r     <= 1'b0;
      in_ready_r <= 1'b0;
      buf_l_r    <= {BITS{1'b0}};
      buf_r_r    <= {BITS{1'b0}};
      sh_l_r     <= {BITS{1'b0}};
      sh_r_r     <= {BITS{1'b0}};
    end else begin
      prescale_r <= fall_s ? {PW{1'b0}} : prescale_r + PW'(1);
      en_r       <= fall_s;
      underrun_r <= frame_start_s && !full_r;
      full_r     <= full_nx_s;
      // Hold in_ready low for the cycle in which the buffer drains
      in_ready_r <= !full_nx_s && !load_s;
      sh_l_r     <= sh_l_nx_s;
      sh_r_r     <= sh_r_nx_s;
      if (fall_s) begin
        sck_r <= 1'b0;
      end else if (rise_s) begin
        sck_r <= 1'b1;
      end else begin
        sck_r <= sck_r;
      end
      if (fall_s) begin
        posn_r <= posn_nx_s;
        ws_r   <= posn_nx_s[5];
        sd_r   <= sd_nx_s;
      end else begin
        posn_r <= posn_r;
        ws_r   <= ws_r;
        sd_r   <= sd_r;
      end
      if (accept_s) begin
        buf_l_r <= left;
        buf_r_r <= right;
      end else begin
        buf_l_r <= buf_l_r;
        buf_r_r <= buf_r_r;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign sck        = sck_r;
  assign ws         = ws_r;
  assign sd         = sd_r;
  assign en         = en_r;
  assign frame_posn = posn_r;
  assign underrun   = underrun_r;

endmodule
